// File: rtl/bisr_stw_systolic_top.sv
// Output-stationary NxN systolic MAC array with per-PE fault injection, Stop-the-World
// self-test and NUM_RU recompute units that repair the entries of faulty PEs.
module bisr_stw_systolic_top #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int WORD_SIZE = 16,
   parameter int NUM_RU    = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [ROWS*COLS*WORD_SIZE-1:0]  top_matrix,
   input  logic [ROWS*COLS*WORD_SIZE-1:0]  left_matrix,
   input  logic [ROWS*COLS*2-1:0]          fault_inject_bus,
   input  logic                            STW_test_load_en,
   input  logic [WORD_SIZE-1:0]            STW_mult_op1,
   input  logic [WORD_SIZE-1:0]            STW_mult_op2,
   input  logic [WORD_SIZE-1:0]            STW_add_op,
   input  logic [WORD_SIZE-1:0]            STW_expected,
   input  logic                            STW_start,
   output logic                            STW_complete_out,
   output logic [ROWS*COLS*WORD_SIZE-1:0]  output_matrix,
   output logic                            matrix_rdy
);

   localparam int unsigned N   = ROWS;
   localparam int unsigned W   = WORD_SIZE;
   localparam int unsigned NPE = ROWS * COLS;
   localparam int unsigned CW  = $clog2(3 * N) + 1;
   localparam int unsigned KW  = $clog2(N + 1);
   localparam int unsigned PW  = (NPE > 1) ? $clog2(NPE) : 1;

   logic [CW-1:0]                cnt;
   logic [COLS-1:0]              output_col_valid;
   logic                         all_valid;
   logic [W-1:0]                 left_feed [ROWS];
   logic [W-1:0]                 top_feed  [COLS];
   logic [ROWS*(COLS-1)*W-1:0]   a_link;
   logic [(ROWS-1)*COLS*W-1:0]   b_link;
   logic [NPE*W-1:0]             pe_res;
   logic [NPE-1:0]               fault_en, fault_val;

   logic [W-1:0]                 stw_op1, stw_op2, stw_add, stw_exp, stw_calc, stw_gold;
   logic                         stw_s1, stw_go;
   logic [NPE-1:0]               STW_result_mat, stw_pass;

   logic                         repair_active, repair_go, all_free, ru_output_valid;
   logic [NPE-1:0]               pending, eff_pend, pend_rest;
   logic [NUM_RU-1:0]            ru_busy, ru_free, sel_v;
   logic [KW-1:0]                ru_k [NUM_RU];
   logic [KW-1:0]                ru_r [NUM_RU], ru_c [NUM_RU], sel_r [NUM_RU], sel_c [NUM_RU];
   logic [PW-1:0]                ru_idx [NUM_RU], sel_idx [NUM_RU];
   logic [W-1:0]                 ru_acc [NUM_RU];

   assign all_valid  = &output_col_valid;
   assign matrix_rdy = all_valid && !repair_active && !STW_complete_out;

   // Skewed feed: row i / column j sees element k at cycle i+k / j+k, zero otherwise.
   always_comb begin
      for (int unsigned i = 0; i < ROWS; i++) begin
         left_feed[i] = '0;
         for (int unsigned k = 0; k < N; k++)
            if (cnt == CW'(i + k)) left_feed[i] = left_matrix[(i*COLS+k)*W +: W];
      end
      for (int unsigned j = 0; j < COLS; j++) begin
         top_feed[j] = '0;
         for (int unsigned k = 0; k < N; k++)
            if (cnt == CW'(j + k)) top_feed[j] = top_matrix[(k*COLS+j)*W +: W];
      end
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
         localparam int unsigned P  = gi * COLS + gj;
         localparam int unsigned FB = (gj * ROWS + gi) * 2;
         logic [W-1:0] a_in, b_in, acc_r;

         if (gj == 0) begin : g_al
            assign a_in = left_feed[gi];
         end else begin : g_an
            assign a_in = a_link[(gi*(COLS-1)+gj-1)*W +: W];
         end
         if (gi == 0) begin : g_bt
            assign b_in = top_feed[gj];
         end else begin : g_bn
            assign b_in = b_link[((gi-1)*COLS+gj)*W +: W];
         end

         if (gj < COLS - 1) begin : g_ap
            logic [W-1:0] a_r;
            always_ff @(posedge clk or negedge rst)
               if (!rst) a_r <= '0;
               else      a_r <= a_in;
            assign a_link[(gi*(COLS-1)+gj)*W +: W] = a_r;
         end
         if (gi < ROWS - 1) begin : g_bp
            logic [W-1:0] b_r;
            always_ff @(posedge clk or negedge rst)
               if (!rst) b_r <= '0;
               else      b_r <= b_in;
            assign b_link[(gi*COLS+gj)*W +: W] = b_r;
         end

         always_ff @(posedge clk or negedge rst)
            if (!rst) acc_r <= '0;
            else      acc_r <= acc_r + a_in * b_in;

         assign fault_en[P]  = fault_inject_bus[FB];
         assign fault_val[P] = fault_inject_bus[FB+1];
         assign pe_res[P*W +: W] = fault_en[P] ? {W{fault_val[P]}} : acc_r;
      end
   end

   // Column c is complete one cycle after PE(N-1,c) takes its last operand pair.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt              <= '0;
         output_col_valid <= '0;
         output_matrix    <= '0;
      end else begin
         if (!all_valid) cnt <= cnt + CW'(1);
         for (int unsigned c = 0; c < COLS; c++) begin
            if (!output_col_valid[c] && cnt == CW'(2*N - 1 + c)) begin
               output_col_valid[c] <= 1'b1;
               for (int unsigned r = 0; r < ROWS; r++)
                  output_matrix[(r*COLS+c)*W +: W] <= pe_res[(r*COLS+c)*W +: W];
            end
         end
         for (int unsigned u = 0; u < NUM_RU; u++)
            if (ru_busy[u] && ru_k[u] == KW'(N))
               output_matrix[ru_idx[u]*W +: W] <= ru_acc[u];
      end
   end

   assign stw_go = STW_start && all_valid && !stw_s1 && !STW_complete_out && !repair_active;

   always_comb begin
      for (int unsigned p = 0; p < NPE; p++)
         stw_pass[p] = fault_en[p] ? ({W{fault_val[p]}} == stw_gold) : (stw_calc == stw_gold);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stw_op1          <= '0;
         stw_op2          <= '0;
         stw_add          <= '0;
         stw_exp          <= '0;
         stw_calc         <= '0;
         stw_gold         <= '0;
         stw_s1           <= 1'b0;
         STW_complete_out <= 1'b0;
         STW_result_mat   <= '1;
      end else begin
         if (STW_test_load_en) begin
            stw_op1 <= STW_mult_op1;
            stw_op2 <= STW_mult_op2;
            stw_add <= STW_add_op;
            stw_exp <= STW_expected;
         end
         stw_s1           <= stw_go;
         STW_complete_out <= stw_s1;
         if (stw_go) begin
            stw_calc <= stw_op1 * stw_op2 + stw_add;
            stw_gold <= stw_exp;
         end
         if (stw_s1) STW_result_mat <= stw_pass;
      end
   end

   // The verdict is consumed directly in the complete cycle so a clean array signs off a cycle later.
   assign repair_go = STW_complete_out || repair_active;
   assign eff_pend  = STW_complete_out ? ~STW_result_mat : pending;

   always_comb begin
      pend_rest = eff_pend;
      for (int unsigned u = 0; u < NUM_RU; u++) begin
         sel_v[u]   = 1'b0;
         sel_idx[u] = '0;
         sel_r[u]   = '0;
         sel_c[u]   = '0;
         for (int unsigned p = 0; p < NPE; p++) begin
            if (!sel_v[u] && pend_rest[p]) begin
               sel_v[u]     = 1'b1;
               sel_idx[u]   = PW'(p);
               sel_r[u]     = KW'(p / COLS);
               sel_c[u]     = KW'(p % COLS);
               pend_rest[p] = 1'b0;
            end
         end
      end
      for (int unsigned u = 0; u < NUM_RU; u++)
         ru_free[u] = !ru_busy[u] || ru_k[u] == KW'(N);
   end

   assign all_free = &ru_free;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending         <= '0;
         repair_active   <= 1'b0;
         ru_output_valid <= 1'b0;
         ru_busy         <= '0;
         for (int unsigned u = 0; u < NUM_RU; u++) begin
            ru_k[u]   <= '0;
            ru_r[u]   <= '0;
            ru_c[u]   <= '0;
            ru_idx[u] <= '0;
            ru_acc[u] <= '0;
         end
      end else begin
         if (stw_go) ru_output_valid <= 1'b0;
         if (repair_go && all_free) begin
            pending <= pend_rest;
            for (int unsigned u = 0; u < NUM_RU; u++) begin
               ru_busy[u] <= sel_v[u];
               ru_idx[u]  <= sel_idx[u];
               ru_r[u]    <= sel_r[u];
               ru_c[u]    <= sel_c[u];
               ru_k[u]    <= '0;
               ru_acc[u]  <= '0;
            end
            if (eff_pend == '0) begin
               ru_output_valid <= 1'b1;
               repair_active   <= 1'b0;
            end else begin
               repair_active   <= 1'b1;
            end
         end else begin
            for (int unsigned u = 0; u < NUM_RU; u++) begin
               if (ru_busy[u]) begin
                  if (ru_k[u] == KW'(N)) begin
                     ru_busy[u] <= 1'b0;
                  end else begin
                     ru_acc[u] <= ru_acc[u]
                                + left_matrix[(ru_r[u]*COLS + ru_k[u])*W +: W]
                                * top_matrix[(ru_k[u]*COLS + ru_c[u])*W +: W];
                     ru_k[u]   <= ru_k[u] + KW'(1);
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bisr_stw_systolic_top.sv
// Self-checking bench: matrix-product reference model with fault/repair bookkeeping,
// a per-cycle output compare process, and literal pins taken from worked examples.
module tb_bisr_stw_systolic_top;

   localparam int N   = 4;
   localparam int W   = 16;
   localparam int NPE = N * N;
   localparam int NRU = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NPE*W-1:0]  top_matrix = '0;
   logic [NPE*W-1:0]  left_matrix = '0;
   logic [NPE*2-1:0]  fault_inject_bus = '0;
   logic              STW_test_load_en = 1'b0;
   logic [W-1:0]      STW_mult_op1 = '0, STW_mult_op2 = '0, STW_add_op = '0, STW_expected = '0;
   logic              STW_start = 1'b0;
   logic              STW_complete_out;
   logic [NPE*W-1:0]  output_matrix;
   logic              matrix_rdy;

   int                checks = 0;
   int                failures = 0;
   logic              chk_en = 1'b0;
   logic [W-1:0]      lm [N][N];
   logic [W-1:0]      tm [N][N];
   logic [W-1:0]      gold [N][N];
   logic              fen [N][N];
   logic              fst [N][N];
   logic              fixed [N][N];
   logic [NPE*W-1:0]  exp_flat = '0;
   logic [W-1:0]      ra, rb, rc, re;
   int                seen;

   bisr_stw_systolic_top #(.ROWS(N), .COLS(N), .WORD_SIZE(W), .NUM_RU(NRU)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .top_matrix       (top_matrix),
      .left_matrix      (left_matrix),
      .fault_inject_bus (fault_inject_bus),
      .STW_test_load_en (STW_test_load_en),
      .STW_mult_op1     (STW_mult_op1),
      .STW_mult_op2     (STW_mult_op2),
      .STW_add_op       (STW_add_op),
      .STW_expected     (STW_expected),
      .STW_start        (STW_start),
      .STW_complete_out (STW_complete_out),
      .output_matrix    (output_matrix),
      .matrix_rdy       (matrix_rdy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Whenever the DUT claims a ready matrix it must match the model's view.
   always @(negedge clk)
      if (rst && chk_en && matrix_rdy) check("out_vs_model", output_matrix, exp_flat);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_data();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            lm[r][c] = '0; tm[r][c] = '0; fen[r][c] = 1'b0; fst[r][c] = 1'b0;
         end
   endtask

   task automatic rand_data();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            lm[r][c] = W'($urandom); tm[r][c] = W'($urandom);
            fen[r][c] = 1'b0; fst[r][c] = 1'b0;
         end
   endtask

   task automatic build_model();
      logic [W-1:0] s;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            left_matrix[(r*N+c)*W +: W]     = lm[r][c];
            top_matrix[(r*N+c)*W +: W]      = tm[r][c];
            fault_inject_bus[(c*N+r)*2]     = fen[r][c];
            fault_inject_bus[(c*N+r)*2 + 1] = fst[r][c];
            fixed[r][c] = 1'b0;
         end
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            s = '0;
            for (int k = 0; k < N; k++) s = s + lm[r][k] * tm[k][c];
            gold[r][c] = s;
         end
   endtask

   task automatic set_exp();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            exp_flat[(r*N+c)*W +: W] = (fen[r][c] && !fixed[r][c]) ? {W{fst[r][c]}} : gold[r][c];
   endtask

   task automatic start_run();
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_out_immediate", output_matrix, '0);
      check("rst_rdy_immediate", matrix_rdy, 1'b0);
      build_model();
      set_exp();
      tick();
      check("rst_out", output_matrix, '0);
      check("rst_complete", STW_complete_out, 1'b0);
      check("rst_result_mat", u_dut.STW_result_mat, 16'hFFFF);
      check("rst_ru_valid", u_dut.ru_output_valid, 1'b0);
      rst = 1'b1;
      chk_en = 1'b1;
   endtask

   task automatic wait_rdy(input int maxc);
      int cyc = 0;
      while (!matrix_rdy && cyc < maxc + 4) begin
         tick();
         cyc++;
      end
      check("rdy_latency", (matrix_rdy && cyc <= maxc), 1'b1);
      check("out_after_rdy", output_matrix, exp_flat);
   endtask

   task automatic run_stw(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ad, input logic [W-1:0] e);
      int nf, cyc, bound;
      logic [NPE-1:0] mexp;
      logic [W-1:0] v;
      logic pass;
      STW_mult_op1 = a; STW_mult_op2 = b; STW_add_op = ad; STW_expected = e;
      STW_test_load_en = 1'b1;
      tick();
      STW_test_load_en = 1'b0;
      STW_start = 1'b1;
      tick();
      STW_start = 1'b0;
      check("stw_no_early_complete", STW_complete_out, 1'b0);
      tick();
      check("stw_complete_pulse", STW_complete_out, 1'b1);
      v = a * b + ad;
      nf = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            pass = fen[r][c] ? ({W{fst[r][c]}} == e) : (v == e);
            mexp[r*N+c] = pass;
            if (!pass) begin
               nf++;
               fixed[r][c] = 1'b1;
            end
         end
      check("stw_result_mat", u_dut.STW_result_mat, mexp);
      set_exp();
      cyc = 0;
      while (!u_dut.ru_output_valid && cyc < 200) begin
         tick();
         cyc++;
      end
      bound = (nf == 0) ? 1 : ((nf + NRU - 1) / NRU) * (N + 1) + 2;
      if (nf == 0) check("ru_latency_zero", cyc, 1);
      else         check("ru_latency", (u_dut.ru_output_valid && cyc <= bound), 1'b1);
      check("stw_complete_dropped", STW_complete_out, 1'b0);
      check("rdy_after_repair", matrix_rdy, 1'b1);
      check("out_after_repair", output_matrix, exp_flat);
   endtask

   initial begin
      // 2x2 worked example embedded in the top-left corner of the 4x4 array.
      clear_data();
      lm[0][0] = 16'd7; lm[0][1] = 16'd6; lm[1][0] = 16'd1; lm[1][1] = 16'd2;
      tm[0][0] = 16'd1; tm[0][1] = 16'd2; tm[1][0] = 16'd3; tm[1][1] = 16'd4;
      start_run();
      check("model_pin00", gold[0][0], 16'd25);
      check("model_pin01", gold[0][1], 16'd38);
      check("model_pin10", gold[1][0], 16'd7);
      check("model_pin11", gold[1][1], 16'd10);
      wait_rdy(3 * N);
      check("t1_out01", output_matrix[(0*N+1)*W +: W], 16'd38);
      check("t1_out11", output_matrix[(1*N+1)*W +: W], 16'd10);

      fen[0][1] = 1'b1; fst[0][1] = 1'b1;
      start_run();
      wait_rdy(3 * N);
      check("t2_out01_stuck", output_matrix[(0*N+1)*W +: W], 16'hFFFF);
      run_stw(16'd4, 16'd3, 16'd0, 16'd12);
      check("t2_result_mat", u_dut.STW_result_mat, 16'hFFFD);
      check("t2_out01_repaired", output_matrix[(0*N+1)*W +: W], 16'd38);

      rand_data();
      fen[0][1] = 1'b1; fst[0][1] = 1'b1;
      fen[1][1] = 1'b1; fst[1][1] = 1'b1;
      fen[2][2] = 1'b1; fst[2][2] = 1'b1;
      fen[3][3] = 1'b1; fst[3][3] = 1'b1;
      start_run();
      wait_rdy(3 * N);
      run_stw(16'd4, 16'd3, 16'd0, 16'd12);
      check("t3_result_mat", u_dut.STW_result_mat, 16'h7BDD);

      rand_data();
      fen[1][0] = 1'b1; fst[1][0] = 1'b0;
      start_run();
      wait_rdy(3 * N);
      check("t4_out10_stuck0", output_matrix[(1*N+0)*W +: W], 16'd0);
      run_stw(16'd4, 16'd3, 16'd0, 16'd12);
      check("t4_out10_repaired", output_matrix[(1*N+0)*W +: W], gold[1][0]);
      run_stw(16'd0, 16'd0, 16'd0, 16'd0);
      check("t4_stuck0_passes", u_dut.STW_result_mat, 16'hFFFF);

      // STW request while the array is still computing must be dropped.
      rand_data();
      start_run();
      STW_mult_op1 = 16'd2; STW_mult_op2 = 16'd2; STW_add_op = 16'd0; STW_expected = 16'd9;
      STW_test_load_en = 1'b1;
      tick();
      STW_test_load_en = 1'b0;
      STW_start = 1'b1;
      tick();
      STW_start = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (STW_complete_out) seen++;
      end
      check("stw_ignored_busy", seen, 0);
      wait_rdy(3 * N - 6);
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom); re = ra * rb + rc;
      run_stw(ra, rb, rc, re);
      check("t5_all_pass", u_dut.STW_result_mat, 16'hFFFF);

      // Reset in the middle of a repair.
      rand_data();
      fen[0][1] = 1'b1; fst[0][1] = 1'b1;
      fen[1][1] = 1'b1; fst[1][1] = 1'b0;
      fen[2][2] = 1'b1; fst[2][2] = 1'b1;
      fen[3][3] = 1'b1; fst[3][3] = 1'b1;
      start_run();
      wait_rdy(3 * N);
      STW_mult_op1 = 16'd4; STW_mult_op2 = 16'd3; STW_add_op = 16'd0; STW_expected = 16'd12;
      STW_test_load_en = 1'b1;
      tick();
      STW_test_load_en = 1'b0;
      STW_start = 1'b1;
      tick();
      STW_start = 1'b0;
      tick();
      tick();
      tick();
      check("t6_in_repair", matrix_rdy, 1'b0);
      start_run();
      wait_rdy(3 * N);
      run_stw(16'd4, 16'd3, 16'd0, 16'd12);

      for (int it = 0; it < 4; it++) begin
         rand_data();
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               if ($urandom_range(0, 5) == 0) begin
                  fen[r][c] = 1'b1;
                  fst[r][c] = 1'($urandom_range(0, 1));
               end
         start_run();
         wait_rdy(3 * N);
         ra = W'($urandom_range(0, 3)); rb = W'($urandom_range(0, 3)); rc = W'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) re = ra * rb + rc;
         else                           re = W'($urandom_range(0, 3));
         run_stw(ra, rb, rc, re);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
